// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the distributed-RAM stream reader.
package ram_pkg;

  localparam int unsigned RamAw = 8;
  localparam int unsigned RamDw = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register carrying {last, data}.
module stream_out_reg #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          in_ready_o,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_last_o,
  input  logic          m_ready_i
);

  logic        valid_q, valid_d;
  logic [DW:0] word_q, word_d;

  // Accept a new word when empty or when the current one leaves this cycle.
  assign in_ready_o = !valid_q || m_ready_i;

  // Next-state: reload on accept, otherwise empty out on handshake.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      word_d  = {in_last_i, in_data_i};
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = word_q[DW-1:0];
  assign m_last_o  = word_q[DW];

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a block of RAM addresses and streams the read words out over valid/ready.
module bram_stream_reader
  import ram_pkg::*;
#(
  parameter int unsigned AW = RamAw,
  parameter int unsigned DW = RamDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] AddrOne = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   RemOne  = {{AW{1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          rd_valid, rd_ready, rd_last;

  // The word being read is the block's final one when one word remains.
  assign rd_last = (rem_q == RemOne);

  // FSM next-state, address and remaining-word counters.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    rd_valid = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = length;
          state_d = (length == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          addr_d = addr_q + AddrOne;
          rem_d  = rem_q - RemOne;
          if (rd_last) state_d = StDrain;
        end
      end
      StDrain: begin
        // Only the final word is left in the output register.
        if (m_valid && m_ready) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  assign ram_addr = addr_q;
  assign busy     = (state_q != StIdle);

  stream_out_reg #(
    .DW (DW)
  ) u_out (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (rd_valid),
    .in_data_i  (ram_dout),
    .in_last_i  (rd_last),
    .in_ready_o (rd_ready),
    .m_valid_o  (m_valid),
    .m_data_o   (m_data),
    .m_last_o   (m_last),
    .m_ready_i  (m_ready)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a 256x32 RAM model preloaded mem[i]=i*3.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic [7:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_addr];

  bram_stream_reader #(
    .AW (8),
    .DW (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    int          mode;       // 0: ready held high, 1: ready pattern 1,0,0,1,0,1
    bit          restart;    // pulse a second start mid-block
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];
  bit   rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input int a);
    return 32'((a & 255) * 3);
  endfunction

  task automatic run_block(input string tag, input vec_t v);
    int          beats = 0;
    int          cyc = 0;
    int          bubbles = 0;
    int          dones = 0;
    int          valid_cycles = 0;
    bit          stalled = 1'b0;
    bit          fin = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    logic [31:0] last_data = '0;

    start     = 1'b1;
    base_addr = v.base;
    length    = v.len;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    if (v.len != 0) begin
      chk({tag, "_no_valid_yet"}, 32'(m_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_latency_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_first_data"}, m_data, v.exp_first);
      chk({tag, "_addr_after_first"}, 32'(ram_addr), 32'((int'(v.base) + 1) & 255));
    end else begin
      chk({tag, "_len0_done"}, 32'(done), 32'd1);
    end

    while (!fin && cyc < 2000) begin
      m_ready = (v.mode == 1) ? rdy_pat[cyc % 6] : 1'b1;
      if (v.restart && cyc == 10) begin
        start     = 1'b1;
        base_addr = 8'h05;
        length    = 9'd3;
      end else begin
        start = 1'b0;
      end
      if (stalled) begin
        chk({tag, "_stall_valid"}, 32'(m_valid), 32'd1);
        chk({tag, "_stall_data"}, m_data, held_data);
        chk({tag, "_stall_last"}, 32'(m_last), 32'(held_last));
      end
      if (m_valid) valid_cycles++;
      if (v.mode == 0 && beats < int'(v.len) && !m_valid) bubbles++;
      if (done) begin
        dones++;
        fin = 1'b1;
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        chk({tag, "_valid_in_done"}, 32'(m_valid), 32'd0);
      end else if (m_valid && m_ready) begin
        chk({tag, "_beat_data"}, m_data, model(int'(v.base) + beats));
        chk({tag, "_beat_last"}, 32'(m_last), 32'(beats == int'(v.len) - 1));
        last_data = m_data;
        beats++;
      end
      stalled   = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      cyc++;
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk({tag, "_finished_in_budget"}, 32'(fin), 32'd1);
    chk({tag, "_beat_count"}, 32'(beats), 32'(v.exp_beats));
    chk({tag, "_valid_cycles_min"}, 32'(valid_cycles >= v.exp_beats), 32'd1);
    chk({tag, "_last_word"}, last_data, v.exp_last);
    if (v.mode == 0) chk({tag, "_bubbles"}, 32'(bubbles), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_busy_low_after"}, 32'(busy), 32'd0);
    chk({tag, "_idle_addr_hold"}, 32'(ram_addr), 32'((int'(v.base) + int'(v.len)) & 255));
    chk({tag, "_dones"}, 32'(dones), 32'd1);
  endtask

  initial begin
    int   seen_done;
    vec_t rv;

    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3);

    vecs[0] = '{base: 8'd10,  len: 9'd4,   mode: 0, restart: 1'b0, exp_beats: 4,
                exp_first: 32'd30,  exp_last: 32'd39};
    vecs[1] = '{base: 8'd10,  len: 9'd4,   mode: 1, restart: 1'b0, exp_beats: 4,
                exp_first: 32'd30,  exp_last: 32'd39};
    vecs[2] = '{base: 8'hFE,  len: 9'd4,   mode: 0, restart: 1'b0, exp_beats: 4,
                exp_first: 32'd762, exp_last: 32'd3};
    vecs[3] = '{base: 8'd0,   len: 9'd0,   mode: 0, restart: 1'b0, exp_beats: 0,
                exp_first: 32'd0,   exp_last: 32'd0};
    vecs[4] = '{base: 8'd0,   len: 9'd256, mode: 0, restart: 1'b1, exp_beats: 256,
                exp_first: 32'd0,   exp_last: 32'd765};

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    #2;
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_block($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of an 8-word block after two accepted beats.
    start     = 1'b1;
    base_addr = 8'd20;
    length    = 9'd8;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_beat0", m_data, 32'd60);
    @(posedge clk); #1;
    chk("abort_beat1", m_data, 32'd63);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("abort_valid_low", 32'(m_valid), 32'd0);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_done_low", 32'(done), 32'd0);
    chk("abort_addr_reset", 32'(ram_addr), 32'd0);
    #1 rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || m_valid || busy) seen_done++;
    end
    chk("abort_quiet_after", 32'(seen_done), 32'd0);

    rv = '{base: 8'd20, len: 9'd8, mode: 1, restart: 1'b0, exp_beats: 8,
           exp_first: 32'd60, exp_last: 32'd81};
    run_block("after_abort", rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
